// File: rtl/paraleloserial_arbiter.sv
// Byte-slot scheduler feeding the 8:1 serializer: training preamble, round-robin
// sharing between byte sources, and idle-symbol fill so the serial stream never stalls.
module paraleloserial_arbiter #(
  parameter int          N_REQ      = 4,
  parameter logic [7:0]  IDLE_BYTE  = 8'hBC,
  parameter int          SYNC_BYTES = 4,
  localparam int         GW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk32_f,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         data_out,
  output logic               valid_out,
  output logic               load,
  output logic [GW-1:0]      grant_id,
  output logic [2:0]         bit_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES);

  state_t         state, state_nxt;
  logic [GW-1:0]  rr_ptr, rr_nxt;
  logic [3:0]     sync_cnt, sync_nxt;
  logic           stop_pend, stop_nxt;
  logic [GW-1:0]  pend_id, pend_id_nxt;
  logic [7:0]     pend_data, pend_data_nxt;
  logic [2:0]     bit_cnt_nxt;
  logic [7:0]     data_nxt;
  logic           valid_nxt;
  logic           load_nxt;
  logic [N_REQ-1:0] ready_nxt;
  logic [GW-1:0]  grant_nxt;

  logic [7:0]     req_bytes [N_REQ];
  logic           found;
  logic [GW-1:0]  winner;
  logic [GW-1:0]  cand;

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = GW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt + 3'd1;
    data_nxt      = data_out;
    valid_nxt     = valid_out;
    load_nxt      = 1'b0;
    ready_nxt     = '0;
    grant_nxt     = grant_id;
    rr_nxt        = rr_ptr;
    sync_nxt      = sync_cnt;
    stop_nxt      = stop_pend;
    pend_id_nxt   = pend_id;
    pend_data_nxt = pend_data;

    unique case (state)
      IDLE: begin
        bit_cnt_nxt = '0;
        data_nxt    = '0;
        valid_nxt   = 1'b0;
        grant_nxt   = '0;
        sync_nxt    = '0;
        stop_nxt    = 1'b0;
        if (enable) begin
          state_nxt = SYNC;
          data_nxt  = IDLE_BYTE;
          load_nxt  = 1'b1;
          sync_nxt  = 4'd1;
        end
      end

      SYNC, RUN: begin
        // The grant is decided one cycle before the slot boundary so that
        // ready is visible for exactly the bit 7 cycle.
        if (bit_cnt == 3'd6) begin
          if (!enable) begin
            stop_nxt = 1'b1;
          end else if ((state == RUN || sync_cnt == SYNC_LAST) && found) begin
            ready_nxt[winner] = 1'b1;
            pend_id_nxt       = winner;
            pend_data_nxt     = req_bytes[winner];
          end
        end

        if (bit_cnt == 3'd7) begin
          if (stop_pend) begin
            state_nxt = IDLE;
            data_nxt  = '0;
            valid_nxt = 1'b0;
            grant_nxt = '0;
            sync_nxt  = '0;
            stop_nxt  = 1'b0;
          end else if (state == SYNC && sync_cnt != SYNC_LAST) begin
            data_nxt  = IDLE_BYTE;
            valid_nxt = 1'b0;
            load_nxt  = 1'b1;
            sync_nxt  = sync_cnt + 4'd1;
          end else begin
            state_nxt = RUN;
            load_nxt  = 1'b1;
            if (|req_ready) begin
              data_nxt  = pend_data;
              valid_nxt = 1'b1;
              grant_nxt = pend_id;
              rr_nxt    = (pend_id == GW'(N_REQ - 1)) ? '0 : pend_id + GW'(1);
            end else begin
              data_nxt  = IDLE_BYTE;
              valid_nxt = 1'b0;
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk32_f) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      load      <= 1'b0;
      req_ready <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      sync_cnt  <= '0;
      stop_pend <= 1'b0;
      pend_id   <= '0;
      pend_data <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      load      <= load_nxt;
      req_ready <= ready_nxt;
      grant_id  <= grant_nxt;
      rr_ptr    <= rr_nxt;
      sync_cnt  <= sync_nxt;
      stop_pend <= stop_nxt;
      pend_id   <= pend_id_nxt;
      pend_data <= pend_data_nxt;
    end
  end

endmodule

// File: tb/tb_paraleloserial_arbiter.sv
// Scoreboard bench for paraleloserial_arbiter: directed slots are queued as expected
// loads and a monitor compares each load strobe against the queue head.
module tb_paraleloserial_arbiter;

  localparam int         N    = 4;
  localparam logic [7:0] IDLE = 8'hBC;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic [1:0] g;
  } slot_t;

  logic           clk32_f = 1'b0;
  logic           reset;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     data_out;
  logic           valid_out;
  logic           load;
  logic [1:0]     grant_id;
  logic [2:0]     bit_cnt;

  slot_t      exp_q [$];
  logic [7:0] src_q [N][$];
  logic       all_valid;
  int         n_total = 0;
  int         n_pass = 0;
  int         ready_pulses = 0;
  int         p0;

  always #5 clk32_f = ~clk32_f;

  paraleloserial_arbiter #(
    .N_REQ(N),
    .IDLE_BYTE(IDLE),
    .SYNC_BYTES(4)
  ) dut (
    .clk32_f(clk32_f),
    .reset(reset),
    .enable(enable),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .data_out(data_out),
    .valid_out(valid_out),
    .load(load),
    .grant_id(grant_id),
    .bit_cnt(bit_cnt)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_slot(input logic [7:0] d, input logic v, input logic [1:0] g);
    slot_t s;
    s.d = d;
    s.v = v;
    s.g = g;
    exp_q.push_back(s);
  endtask

  function automatic logic [31:0] outs();
    return 32'({data_out, valid_out, load, req_ready, grant_id, bit_cnt});
  endfunction

  task automatic wait_bit(input logic [2:0] n);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk32_f);
      if (bit_cnt == n) return;
    end
    n_total++;
    $display("[TB] FAIL wait_bit: bit_cnt never reached %0d (last 0x%0h)", n, bit_cnt);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk32_f);
      if (exp_q.size() == 0) return;
    end
    n_total++;
    $display("[TB] FAIL drain_timeout: %0d expected loads never seen, required 0", exp_q.size());
    exp_q.delete();
  endtask

  // Monitor: every load strobe is matched against the scoreboard head.
  task automatic run_monitor();
    slot_t e;
    forever begin
      @(negedge clk32_f);
      if (req_ready != '0) begin
        ready_pulses++;
        check_output("ready_at_bit7", 32'(bit_cnt), 32'd7);
        check_output("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      end
      if (load) begin
        check_output("load_at_bit0", 32'(bit_cnt), 32'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("[TB] FAIL unexpected_load: got data 0x%0h valid %0d, required no load", data_out, valid_out);
        end else begin
          e = exp_q.pop_front();
          check_output("slot_data", 32'(data_out), 32'(e.d));
          check_output("slot_valid", 32'(valid_out), 32'(e.v));
          check_output("slot_grant", 32'(grant_id), 32'(e.g));
        end
      end
    end
  endtask

  // Requester model: holds valid/data until its handshake, then advances its queue.
  task automatic run_driver();
    logic [N-1:0] hs;
    forever begin
      @(negedge clk32_f);
      hs = req_valid & req_ready;
      @(posedge clk32_f);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        req_valid[i]       = all_valid || (src_q[i].size() > 0);
        req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    all_valid = 1'b1;
    req_valid = '1;
    req_data  = '0;
    fork
      run_monitor();
      run_driver();
    join_none

    repeat (4) begin
      @(negedge clk32_f);
      check_output("reset_outputs", outs(), 32'd0);
    end
    reset     = 1'b1;
    enable    = 1'b0;
    all_valid = 1'b0;
    repeat (3) begin
      @(negedge clk32_f);
      check_output("idle_hold", outs(), 32'd0);
    end

    // Training: four preamble bytes then idle fill.
    repeat (6) push_slot(IDLE, 1'b0, 2'd0);
    enable = 1'b1;
    wait_drain();
    check_output("training_no_grant", 32'(ready_pulses), 32'd0);

    // Round robin across all four sources, two bytes each.
    wait_bit(3'd2);
    p0 = ready_pulses;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        src_q[i].push_back(8'h10 + 8'(i));
        push_slot(8'h10 + 8'(i), 1'b1, 2'(i));
      end
    end
    push_slot(IDLE, 1'b0, 2'd3);
    wait_drain();
    check_output("rr_ready_pulses", 32'(ready_pulses - p0), 32'd8);

    // Single source back-to-back.
    wait_bit(3'd2);
    p0 = ready_pulses;
    src_q[0].push_back(8'hFF);
    src_q[0].push_back(8'hAA);
    src_q[0].push_back(8'h25);
    src_q[0].push_back(8'hEE);
    push_slot(8'hFF, 1'b1, 2'd0);
    push_slot(8'hAA, 1'b1, 2'd0);
    push_slot(8'h25, 1'b1, 2'd0);
    push_slot(8'hEE, 1'b1, 2'd0);
    wait_drain();
    check_output("single_ready_pulses", 32'(ready_pulses - p0), 32'd4);

    // Late request: valid rises during the bit 7 cycle and misses this slot.
    wait_bit(3'd2);
    wait_bit(3'd6);
    p0 = ready_pulses;
    src_q[2].push_back(8'h5A);
    push_slot(IDLE, 1'b0, 2'd0);
    push_slot(8'h5A, 1'b1, 2'd2);
    wait_drain();
    check_output("late_ready_pulses", 32'(ready_pulses - p0), 32'd1);

    // Disable mid-slot: the shifting byte completes, then the lane idles.
    wait_bit(3'd2);
    wait_bit(3'd3);
    p0 = ready_pulses;
    enable = 1'b0;
    src_q[1].push_back(8'h77);
    wait_bit(3'd7);
    check_output("disable_current_byte", 32'({data_out, valid_out}), 32'({8'h5A, 1'b1}));
    @(negedge clk32_f);
    check_output("disable_idle", outs(), 32'd0);
    repeat (12) @(negedge clk32_f);
    check_output("disable_stays_idle", outs(), 32'd0);
    check_output("disable_no_grant", 32'(ready_pulses - p0), 32'd0);

    // Re-enable: rr_ptr kept at 3, so source 3 wins over source 1.
    src_q[3].push_back(8'h33);
    repeat (4) push_slot(IDLE, 1'b0, 2'd0);
    push_slot(8'h33, 1'b1, 2'd3);
    push_slot(8'h77, 1'b1, 2'd1);
    p0 = ready_pulses;
    enable = 1'b1;
    wait_drain();
    check_output("reenable_ready_pulses", 32'(ready_pulses - p0), 32'd2);

    // Reset mid-slot: outputs clear on the next edge and rr_ptr returns to 0.
    wait_bit(3'd2);
    wait_bit(3'd4);
    reset = 1'b0;
    src_q[1].push_back(8'hC1);
    src_q[3].push_back(8'hC3);
    @(negedge clk32_f);
    check_output("midrun_reset", outs(), 32'd0);
    repeat (3) begin
      @(negedge clk32_f);
      check_output("midrun_reset_hold", outs(), 32'd0);
    end
    repeat (4) push_slot(IDLE, 1'b0, 2'd0);
    push_slot(8'hC1, 1'b1, 2'd1);
    push_slot(8'hC3, 1'b1, 2'd3);
    reset = 1'b1;
    wait_drain();

    wait_bit(3'd2);
    enable = 1'b0;
    repeat (20) @(negedge clk32_f);
    check_output("end_idle", outs(), 32'd0);
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
